// File: rtl/shift_pkg.sv
// Shared op-codes, FSM states and small helpers for the shift sequencer.
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_rotate(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_sequencer_barrel_shifter.sv
// Combinational log-stage barrel shifter: left/right, logical or arithmetic.
// Left shifts are done as right shifts on the bit-reversed operand so only one shifter array exists.
module BarrelShifter #(
  parameter int width     = 32,
  parameter int bitLength = $clog2(width)
) (
  input  logic [width-1:0]     A,
  input  logic [bitLength-1:0] shamt,
  input  logic                 arith,
  input  logic                 right,
  output logic [width-1:0]     Y
);

  logic             fill;
  logic [width-1:0] a_rev;
  logic [width-1:0] s;
  logic [width-1:0] s_rev;

  // Sign fill only makes sense for right shifts.
  assign fill = arith & right & A[width-1];

  always_comb begin
    for (int i = 0; i < width; i++) begin
      a_rev[i] = A[width-1-i];
    end
  end

  always_comb begin
    s = right ? A : a_rev;
    for (int i = 0; i < bitLength; i++) begin
      if (shamt[i]) begin
        s = (s >> (2**i)) | (fill ? ~({width{1'b1}} >> (2**i)) : '0);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < width; i++) begin
      s_rev[i] = s[width-1-i];
    end
  end

  assign Y = right ? s : s_rev;

endmodule

// File: rtl/shift_sequencer.sv
// Valid/ready sequencer around one BarrelShifter: one pass for SLL/SRL/SRA/PASS,
// two ORed passes for nonzero rotates; registered result held until consumed.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int width     = 32,
  parameter int bitLength = $clog2(width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     in_a,
  input  logic [bitLength-1:0] in_shamt,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     out_result,
  output logic                 busy
);

  state_e                 state_q, state_d;
  logic [width-1:0]       a_q;
  logic [bitLength-1:0]   shamt_q;
  logic [2:0]             op_q;
  logic [width-1:0]       acc_q, acc_d;
  logic [width-1:0]       out_result_q, out_result_d;

  logic [width-1:0]       sh_a;
  logic [bitLength-1:0]   sh_shamt;
  logic                   sh_arith;
  logic                   sh_right;
  logic [width-1:0]       sh_out;

  // Complement for the second rotate pass; the extra bit keeps width itself representable.
  logic [bitLength:0]     comp;
  logic                   comp_msb_unused;

  assign comp            = (bitLength+1)'(width) - {1'b0, shamt_q};
  assign comp_msb_unused = comp[bitLength];

  assign in_ready   = (state_q == ST_IDLE) && !rst;
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = out_result_q;

  BarrelShifter #(
    .width     (width),
    .bitLength (bitLength)
  ) u_shifter (
    .A     (sh_a),
    .shamt (sh_shamt),
    .arith (sh_arith),
    .right (sh_right),
    .Y     (sh_out)
  );

  always_comb begin
    sh_a     = a_q;
    sh_shamt = shamt_q;
    sh_arith = 1'b0;
    sh_right = 1'b0;
    if (state_q == ST_PASS2) begin
      sh_shamt = comp[bitLength-1:0];
      sh_right = (op_q != OP_ROR);
    end else begin
      case (op_q)
        OP_SLL:  sh_right = 1'b0;
        OP_SRL:  sh_right = 1'b1;
        OP_SRA: begin
          sh_arith = 1'b1;
          sh_right = 1'b1;
        end
        OP_ROL:  sh_right = 1'b0;
        OP_ROR:  sh_right = 1'b1;
        default: sh_shamt = '0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    out_result_d = out_result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_PASS1;
      end
      ST_PASS1: begin
        acc_d = sh_out;
        if (is_rotate(op_q) && (shamt_q != '0)) begin
          state_d = ST_PASS2;
        end else begin
          out_result_d = sh_out;
          state_d      = ST_DONE;
        end
      end
      ST_PASS2: begin
        out_result_d = acc_q | sh_out;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      out_result_q <= out_result_d;
    end
  end

  // Operands and accumulator carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (in_valid && in_ready) begin
      a_q     <= in_a;
      shamt_q <= in_shamt;
      op_q    <= in_op;
    end
  end

endmodule
